rv32m_muldiv_unit: RTL and testbench

Iterative RV32M multiply/divide execution unit. It sits directly downstream of the register file and takes rs1/rs2 read data as operands. It produces a write-back result, destination index and write strobe that feed the register file's WD/rd/RegWrite path through the write-back mux. It runs multi-cycle and stalls the core via busy until the result is ready.

---
 rtl/rv32m_muldiv_unit.sv | 163 ++++++++++++++++
 tb/tb_rv32m_muldiv_unit.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/rv32m_muldiv_unit.sv
// Iterative RV32M multiply/divide unit: 32-step shift-add multiply and restoring divide.
// Optional macro RV32M_FAST_MUL_EN: single-cycle combinational multiply (IDLE->FIX->DONE).
module rv32m_muldiv_unit #(
   parameter int XLEN       = 32,
   parameter int REG_ADDR_W = 5
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [2:0]            funct3,
   input  logic [XLEN-1:0]       op_a,
   input  logic [XLEN-1:0]       op_b,
   input  logic [REG_ADDR_W-1:0] rd_in,
   output logic                  busy,
   output logic                  done,
   output logic [XLEN-1:0]       result,
   output logic [REG_ADDR_W-1:0] rd_out,
   output logic                  reg_write
);

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

   state_t                  state_q, state_d;
   logic [4:0]              cnt_q, cnt_d;
   logic [2*XLEN-1:0]       acc_q, acc_d;
   logic [XLEN-1:0]         opnd_q, opnd_d;
   logic [2:0]              f3_q, f3_d;
   logic                    negq_q, negq_d;
   logic                    negr_q, negr_d;
   logic [REG_ADDR_W-1:0]   rd_q, rd_d;
   logic [XLEN-1:0]         result_q, result_d;

   logic                    sgn_a, sgn_b, sign_a, sign_b;
   logic [XLEN-1:0]         a_mag, b_mag;
   logic                    div0, ovf;
   logic [XLEN:0]           mul_sum;
   logic [XLEN:0]           div_trial;
   logic [2*XLEN-1:0]       mul_step, div_step;
   logic [2*XLEN-1:0]       prod_fix;
   logic [XLEN-1:0]         quo_fix, rem_fix;
`ifdef RV32M_FAST_MUL_EN
   logic [2*XLEN-1:0]       fast_prod;
`endif

   // Operand decode and magnitudes; 0x80000000 negates to itself, read as unsigned
   always_comb begin
      sgn_a  = (funct3 == 3'b001) || (funct3 == 3'b010) || (funct3 == 3'b100) || (funct3 == 3'b110);
      sgn_b  = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
      sign_a = sgn_a & op_a[XLEN-1];
      sign_b = sgn_b & op_b[XLEN-1];
      a_mag  = sign_a ? (~op_a + 1'b1) : op_a;
      b_mag  = sign_b ? (~op_b + 1'b1) : op_b;
      div0   = funct3[2] && (op_b == '0);
      ovf    = ((funct3 == 3'b100) || (funct3 == 3'b110)) &&
               (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == '1);
`ifdef RV32M_FAST_MUL_EN
      fast_prod = {{XLEN{1'b0}}, a_mag} * {{XLEN{1'b0}}, b_mag};
`endif
   end

   // Iteration datapath: acc holds {hi, multiplier} for multiply, {remainder, dividend/quotient} for divide
   always_comb begin
      mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
      mul_step  = {mul_sum, acc_q[XLEN-1:1]};
      div_trial = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]} - {1'b0, opnd_q};
      div_step  = div_trial[XLEN] ? {acc_q[2*XLEN-2:0], 1'b0}
                                  : {div_trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
      prod_fix  = negq_q ? (~acc_q + 1'b1) : acc_q;
      quo_fix   = negq_q ? (~acc_q[XLEN-1:0] + 1'b1) : acc_q[XLEN-1:0];
      rem_fix   = negr_q ? (~acc_q[2*XLEN-1:XLEN] + 1'b1) : acc_q[2*XLEN-1:XLEN];
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      opnd_d   = opnd_q;
      f3_d     = f3_q;
      negq_d   = negq_q;
      negr_d   = negr_q;
      rd_d     = rd_q;
      result_d = result_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               f3_d   = funct3;
               rd_d   = rd_in;
               negq_d = sign_a ^ sign_b;
               negr_d = sign_a;
               cnt_d  = '0;
               if (div0) begin
                  result_d = funct3[1] ? op_a : '1;
                  state_d  = S_DONE;
               end else if (ovf) begin
                  result_d = funct3[1] ? '0 : op_a;
                  state_d  = S_DONE;
               end else if (funct3[2]) begin
                  acc_d   = {{XLEN{1'b0}}, a_mag};
                  opnd_d  = b_mag;
                  state_d = S_CALC;
               end else begin
`ifdef RV32M_FAST_MUL_EN
                  acc_d   = fast_prod;
                  state_d = S_FIX;
`else
                  acc_d   = {{XLEN{1'b0}}, b_mag};
                  opnd_d  = a_mag;
                  state_d = S_CALC;
`endif
               end
            end else begin
               state_d = S_IDLE;
            end
         end
         S_CALC: begin
            cnt_d = cnt_q + 1'b1;
            acc_d = f3_q[2] ? div_step : mul_step;
            if (cnt_q == 5'd31) state_d = S_FIX;
         end
         S_FIX: begin
            case (f3_q)
               3'b000:                 result_d = prod_fix[XLEN-1:0];
               3'b001, 3'b010, 3'b011: result_d = prod_fix[2*XLEN-1:XLEN];
               3'b100, 3'b101:         result_d = quo_fix;
               default:                result_d = rem_fix;
            endcase
            state_d = S_DONE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         acc_q    <= '0;
         opnd_q   <= '0;
         f3_q     <= '0;
         negq_q   <= 1'b0;
         negr_q   <= 1'b0;
         rd_q     <= '0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         opnd_q   <= opnd_d;
         f3_q     <= f3_d;
         negq_q   <= negq_d;
         negr_q   <= negr_d;
         rd_q     <= rd_d;
         result_q <= result_d;
      end
   end

   assign busy      = (state_q == S_CALC) || (state_q == S_FIX);
   assign done      = (state_q == S_DONE);
   assign reg_write = done && (rd_q != '0);
   assign result    = result_q;
   assign rd_out    = rd_q;

endmodule

// File: tb/tb_rv32m_muldiv_unit.sv
// Directed bench for rv32m_muldiv_unit with a cycle-level reference model and literal checks.
module tb_rv32m_muldiv_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [2:0]  funct3 = '0;
   logic [31:0] op_a = '0;
   logic [31:0] op_b = '0;
   logic [4:0]  rd_in = '0;
   logic        busy, done, reg_write;
   logic [31:0] result;
   logic [4:0]  rd_out;

   int errors = 0;
   int checks = 0;
   logic chk_en = 1'b0;

`ifdef RV32M_FAST_MUL_EN
   localparam int LMUL = 1;
`else
   localparam int LMUL = 33;
`endif

   rv32m_muldiv_unit #(.XLEN(32), .REG_ADDR_W(5)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .funct3(funct3),
      .op_a(op_a), .op_b(op_b), .rd_in(rd_in), .busy(busy), .done(done),
      .result(result), .rd_out(rd_out), .reg_write(reg_write)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Architectural result from the RV32M rules, using plain wide arithmetic
   function automatic logic [31:0] model_res(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      logic signed [63:0] sa, sb, ub, sp;
      logic [63:0]        up;
      logic signed [31:0] a32, b32, t;
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      ub = {32'b0, b};
      a32 = a;
      b32 = b;
      model_res = '0;
      case (f)
         3'd0: begin sp = sa * sb; model_res = sp[31:0]; end
         3'd1: begin sp = sa * sb; model_res = sp[63:32]; end
         3'd2: begin sp = sa * ub; model_res = sp[63:32]; end
         3'd3: begin up = {32'b0, a} * {32'b0, b}; model_res = up[63:32]; end
         3'd4: begin
            if (b == 0) model_res = 32'hFFFF_FFFF;
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) model_res = 32'h8000_0000;
            else begin t = a32 / b32; model_res = t; end
         end
         3'd5: model_res = (b == 0) ? 32'hFFFF_FFFF : a / b;
         3'd6: begin
            if (b == 0) model_res = a;
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) model_res = 0;
            else begin t = a32 % b32; model_res = t; end
         end
         default: model_res = (b == 0) ? a : a % b;
      endcase
   endfunction

   // Edges from the start-sampling edge until done is visible
   function automatic int model_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      if (f[2] && b == 0) return 0;
      if ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 0;
      if (!f[2]) return LMUL;
      return 33;
   endfunction

   logic        m_act = 1'b0, m_done = 1'b0;
   int          m_left = 0;
   logic [31:0] m_res = '0, m_pend = '0;
   logic [4:0]  m_rd = '0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_act  <= 1'b0;
         m_left <= 0;
         m_done <= 1'b0;
         m_res  <= '0;
         m_rd   <= '0;
      end else begin
         m_done <= 1'b0;
         if (m_act) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
               m_act  <= 1'b0;
               m_done <= 1'b1;
               m_res  <= m_pend;
            end
         end else if (start) begin
            m_rd <= rd_in;
            if (model_lat(funct3, op_a, op_b) == 0) begin
               m_done <= 1'b1;
               m_res  <= model_res(funct3, op_a, op_b);
            end else begin
               m_act  <= 1'b1;
               m_left <= model_lat(funct3, op_a, op_b);
               m_pend <= model_res(funct3, op_a, op_b);
            end
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("busy", busy, m_act);
         chk("done", done, m_done);
         chk("reg_write", reg_write, m_done && (m_rd != 0));
         chk("result", result, m_res);
         chk("rd_out", rd_out, m_rd);
      end
   end

   task automatic run(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] rd, input logic [31:0] exp, input int lat, input int inj_at);
      int n;
      @(posedge clk); #1;
      start = 1'b1; funct3 = f; op_a = a; op_b = b; rd_in = rd;
      @(posedge clk); #1;
      start = 1'b0; op_a = $urandom; op_b = $urandom; rd_in = 5'(n + 3);
      n = 0;
      while (!done && n < 40) begin
         @(posedge clk); #1;
         n++;
         if (inj_at > 0 && n == inj_at - 1) begin
            start = 1'b1; funct3 = 3'd7; op_a = 32'd55; op_b = 32'd4; rd_in = 5'd1;
         end else begin
            start = 1'b0;
         end
      end
      start = 1'b0;
      chk("latency", n, lat);
      chk("lit_result", result, exp);
      chk("lit_rd_out", rd_out, rd);
      chk("lit_reg_write", reg_write, rd != 0);
      @(posedge clk); #1;
      chk("done_one_cycle", done, 0);
   endtask

   initial begin
      int seen;
      @(posedge clk);
      chk_en = 1'b1;
      @(posedge clk); #1;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_result", result, 0);
      rst_n = 1'b1;

      run(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB, LMUL, 0);
      run(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd3, 32'h4000_0000, LMUL, 0);
      run(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 32'hFFFF_FFFE, LMUL, 0);
      run(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, 32'hFFFF_FFFF, LMUL, 0);
      run(3'd5, 32'd100, 32'd7, 5'd7, 32'd14, 33, 0);
      run(3'd7, 32'd100, 32'd7, 5'd8, 32'd2, 33, 0);
      run(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd9, 32'hFFFF_FFFD, 33, 0);
      run(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd10, 32'hFFFF_FFFF, 33, 0);
      run(3'd4, 32'h1234, 32'd0, 5'd11, 32'hFFFF_FFFF, 0, 0);
      run(3'd6, 32'h1234, 32'd0, 5'd12, 32'h1234, 0, 0);
      run(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'h8000_0000, 0, 0);
      run(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'd0, 0, 0);
      run(3'd1, 32'h8000_0000, 32'h7FFF_FFFF, 5'd16, 32'hC000_0000, LMUL, 0);
      run(3'd4, 32'd1000, 32'd10, 5'd15, 32'd100, 33, 10);
      run(3'd5, 32'd50, 32'd5, 5'd0, 32'd10, 33, 0);

      // Abort a multiply with an asynchronous reset partway through
      @(posedge clk); #1;
      start = 1'b1; funct3 = 3'd0; op_a = 32'd7; op_b = 32'hFFFF_FFFD; rd_in = 5'd5;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (14) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      chk("abort_reg_write", reg_write, 0);
      chk("abort_result", result, 0);
      chk("abort_rd_out", rd_out, 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      seen = 0;
      repeat (30) begin
         @(posedge clk); #1;
         if (done) seen++;
      end
      chk("abort_no_done", seen, 0);
      run(3'd5, 32'd9, 32'd3, 5'd2, 32'd3, 33, 0);

      repeat (2) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
